axi_sram_slave: RTL and testbench

AXI3 slave memory responder, the receiving end of the cache-to-AXI bridge. It accepts AR/R and AW/W/B traffic and serves it from an internal word-addressed SRAM array. It is used as the bench/SoC memory model behind the bridge. Read and write channels run independently and concurrently.

---
 rtl/axi_sram_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave -- AXI3 slave memory responder backed by a word-addressed SRAM.
//
// Purpose: serves AR/R and AW/W/B traffic from an internal 2^ADDR_W x 32-bit array.
// Read and write channels are independent and may run concurrently.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   axi_ar* / axi_arready       read address channel (size/lock/cache/prot ignored)
//   axi_r*  / axi_rready        read data channel
//   axi_aw* / axi_awready       write address channel (size/lock/cache/prot ignored)
//   axi_w*  / axi_wready        write data channel (wid ignored, wstrb selects bytes)
//   axi_b*  / axi_bready        write response channel
//
// Optional build macro: AXI_SLV_RAND_STALL_EN -- LFSR-driven random back-pressure
// on arready/awready/wready and delayed R beats.
module axi_sram_slave #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_MASK = 32'h0000_3FFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic [1:0]  axi_arlock,
  input  logic [3:0]  axi_arcache,
  input  logic [2:0]  axi_arprot,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic [1:0]  axi_awlock,
  input  logic [3:0]  axi_awcache,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [3:0]  axi_wid,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  logic stall;
`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  logic [31:0]       ar_masked, aw_masked;
  logic [ADDR_W-1:0] ar_index, aw_index;
  assign ar_masked = axi_araddr & BASE_MASK;
  assign aw_masked = axi_awaddr & BASE_MASK;
  assign ar_index  = ar_masked[ADDR_W+1:2];
  assign aw_index  = aw_masked[ADDR_W+1:2];

  // ---------------- read channel ----------------
  r_state_t          r_state, r_state_nxt;
  logic [3:0]        r_id;
  logic [ADDR_W-1:0] r_idx, r_idx_inc;
  logic [7:0]        r_len, r_cnt;
  logic              r_err, r_valid, r_last, ar_hs, r_hs;
  logic [31:0]       r_data;

  assign r_idx_inc = r_idx + ADDR_W'(1);
  assign r_last    = (r_state == R_BURST) && (r_cnt == r_len);
  assign ar_hs     = axi_arvalid && axi_arready;
  assign r_hs      = r_valid && axi_rready;

  always_comb begin
    r_state_nxt = r_state;
    axi_arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi_arready = !stall;
        if (axi_arvalid && !stall) r_state_nxt = R_BURST;
      end
      R_BURST: if (r_hs && r_last) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_state_nxt;
  end

  // rdata is loaded from the array with a non-blocking read, so a write landing
  // on the same edge is not visible until the following load.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= axi_arid;
      r_idx   <= ar_index;
      r_len   <= axi_arlen;
      r_cnt   <= '0;
      r_err   <= (axi_arburst != 2'b01);
      r_data  <= mem[ar_index];
      r_valid <= 1'b1;
    end else if (r_state == R_BURST) begin
      if (r_hs) begin
        if (r_last) begin
          r_valid <= 1'b0;
        end else begin
          r_idx   <= r_idx_inc;
          r_cnt   <= r_cnt + 8'd1;
          r_data  <= mem[r_idx_inc];
          r_valid <= !stall;
        end
      end else if (!r_valid && !stall) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign axi_rid    = r_id;
  assign axi_rdata  = r_data;
  assign axi_rresp  = r_err ? 2'b10 : 2'b00;
  assign axi_rlast  = r_last;
  assign axi_rvalid = r_valid;

  // ---------------- write channel ----------------
  w_state_t          w_state, w_state_nxt;
  logic [3:0]        w_id;
  logic [ADDR_W-1:0] w_idx;
  logic [7:0]        w_len, w_cnt;
  logic              w_sup, w_err, aw_hs, w_hs, w_final;

  assign aw_hs   = axi_awvalid && axi_awready;
  assign w_hs    = axi_wvalid && axi_wready;
  assign w_final = (w_cnt == w_len);

  always_comb begin
    w_state_nxt = w_state;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi_awready = !stall;
        if (axi_awvalid && !stall) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi_wready = !stall;
        if (axi_wvalid && !stall && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_state_nxt;
  end

  // Burst length comes from awlen; wlast only feeds the error flag, set when
  // it disagrees with the beat counter on any beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_sup <= 1'b0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id  <= axi_awid;
      w_idx <= aw_index;
      w_len <= axi_awlen;
      w_cnt <= '0;
      w_sup <= (axi_awburst != 2'b01);
      w_err <= (axi_awburst != 2'b01);
    end else if (w_hs) begin
      w_idx <= w_idx + ADDR_W'(1);
      w_cnt <= w_cnt + 8'd1;
      if (w_final != axi_wlast) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_hs && !w_sup) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) mem[w_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  assign axi_bid   = w_id;
  assign axi_bresp = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;

  logic unused_ok;
  assign unused_ok = ^{axi_arsize, axi_arlock, axi_arcache, axi_arprot,
                       axi_awsize, axi_awlock, axi_awcache, axi_awprot, axi_wid,
                       ar_masked[31:ADDR_W+2], ar_masked[1:0],
                       aw_masked[31:ADDR_W+2], aw_masked[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst, axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid, axi_arready;
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst, axi_awlock;
  logic [3:0]  axi_awcache;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid, axi_awready;
  logic [3:0]  axi_wid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(12), .BASE_MASK(32'h0000_3FFF)) dut (
    .clk(clk), .resetn(resetn),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  int n_cmp, n_bad;

  // results captured by the stimulus tasks
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  logic [1:0]  rd_resp [16];
  int          rd_n, rd_cyc;
  logic        rd_first, rd_ok;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  logic        wr_ok;

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [31:0] base, input logic [3:0] strb,
                           input int wlast_beat);
    int cyc;
    wr_ok = 1'b1;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst;
    axi_awvalid = 1'b1;
    cyc = 0;
    while (!axi_awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!axi_awready) wr_ok = 1'b0;
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      axi_wvalid = 1'b1; axi_wdata = base + 32'(b); axi_wstrb = strb;
      axi_wlast = (b == wlast_beat);
      cyc = 0;
      while (!axi_wready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      if (!axi_wready) wr_ok = 1'b0;
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
    cyc = 0;
    while (!axi_bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!axi_bvalid) wr_ok = 1'b0;
    wr_resp = axi_bresp; wr_bid = axi_bid;
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
    int cyc;
    rd_n = 0; rd_ok = 1'b1;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst;
    axi_arvalid = 1'b1; axi_rready = 1'b1;
    cyc = 0;
    while (!axi_arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (!axi_arready) rd_ok = 1'b0;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    rd_first = axi_rvalid;
    rd_cyc = 0;
    while (rd_n <= int'(len) && rd_cyc < 64) begin
      if (axi_rvalid) begin
        if (rd_n < 16) begin
          rd_data[rd_n] = axi_rdata; rd_last[rd_n] = axi_rlast;
          rd_id[rd_n] = axi_rid; rd_resp[rd_n] = axi_rresp;
        end
        rd_n++;
      end
      @(posedge clk); #1;
      rd_cyc++;
    end
    if (rd_n != int'(len) + 1) rd_ok = 1'b0;
    axi_rready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (axi_arready !== 1'b1) begin n_bad++; $display("FAIL reset_arready: got %b expected 1", axi_arready); end
    n_cmp++; if (axi_awready !== 1'b1) begin n_bad++; $display("FAIL reset_awready: got %b expected 1", axi_awready); end
    n_cmp++; if (axi_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b expected 0", axi_rvalid); end
    n_cmp++; if (axi_bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %b expected 0", axi_bvalid); end
    n_cmp++; if (axi_rlast !== 1'b0) begin n_bad++; $display("FAIL reset_rlast: got %b expected 0", axi_rlast); end
    n_cmp++; if (axi_wready !== 1'b0) begin n_bad++; $display("FAIL reset_wready: got %b expected 0", axi_wready); end
    n_cmp++; if ({axi_rid, axi_bid, axi_rresp, axi_bresp} !== 12'h000) begin n_bad++; $display("FAIL reset_ids: got %h expected 000", {axi_rid, axi_bid, axi_rresp, axi_bresp}); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_burst;
    axi_write(4'd2, 32'h0, 8'd7, 2'b01, 32'h1000_0000, 4'hF, 7);
    n_cmp++; if (!wr_ok || wr_resp !== 2'b00) begin n_bad++; $display("FAIL preload_bresp: got ok=%b resp=%b expected ok=1 resp=00", wr_ok, wr_resp); end
    read_burst(4'd1, 32'h0, 8'd7, 2'b01);
    n_cmp++; if (!rd_ok) begin n_bad++; $display("FAIL burst_beats: got %0d expected 8", rd_n); end
    n_cmp++; if (rd_first !== 1'b1) begin n_bad++; $display("FAIL burst_first_latency: got rvalid=%b expected 1", rd_first); end
    n_cmp++; if (rd_cyc !== 8) begin n_bad++; $display("FAIL burst_no_bubbles: got %0d cycles expected 8", rd_cyc); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_data[i] !== 32'h1000_0000 + 32'(i)) begin n_bad++; $display("FAIL burst_data[%0d]: got %h expected %h", i, rd_data[i], 32'h1000_0000 + 32'(i)); end
      n_cmp++; if (rd_last[i] !== (i == 7)) begin n_bad++; $display("FAIL burst_rlast[%0d]: got %b expected %b", i, rd_last[i], (i == 7)); end
      n_cmp++; if (rd_id[i] !== 4'd1 || rd_resp[i] !== 2'b00) begin n_bad++; $display("FAIL burst_id_resp[%0d]: got %h/%b expected 1/00", i, rd_id[i], rd_resp[i]); end
    end
    n_cmp++; if (axi_rvalid !== 1'b0) begin n_bad++; $display("FAIL burst_end_rvalid: got %b expected 0", axi_rvalid); end
  endtask

  task automatic test_write_strobe;
    axi_write(4'd3, 32'h40, 8'd0, 2'b01, 32'h1122_3344, 4'hF, 0);
    axi_write(4'd1, 32'h40, 8'd0, 2'b01, 32'hDEAD_BEEF, 4'b0101, 0);
    n_cmp++; if (!wr_ok) begin n_bad++; $display("FAIL strobe_handshake: got ok=%b expected 1", wr_ok); end
    n_cmp++; if (wr_bid !== 4'd1 || wr_resp !== 2'b00) begin n_bad++; $display("FAIL strobe_b: got bid=%h bresp=%b expected 1/00", wr_bid, wr_resp); end
    read_burst(4'd0, 32'h40, 8'd0, 2'b01);
    n_cmp++; if (!rd_ok || rd_data[0] !== 32'h11AD_33EF) begin n_bad++; $display("FAIL strobe_data: got %h expected 11ad33ef", rd_data[0]); end
  endtask

  task automatic test_read_wrap;
    // words 4095,0,1,2 via a wrapping write, then read through the mask alias
    axi_write(4'd4, 32'h3FFC, 8'd3, 2'b01, 32'hA000_0000, 4'hF, 3);
    read_burst(4'd5, 32'h0001_3FFC, 8'd3, 2'b01);
    n_cmp++; if (!rd_ok) begin n_bad++; $display("FAIL wrap_beats: got %0d expected 4", rd_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_data[i] !== 32'hA000_0000 + 32'(i)) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rd_data[i], 32'hA000_0000 + 32'(i)); end
      n_cmp++; if (rd_last[i] !== (i == 3)) begin n_bad++; $display("FAIL wrap_rlast[%0d]: got %b expected %b", i, rd_last[i], (i == 3)); end
    end
    read_burst(4'd5, 32'h0, 8'd0, 2'b01);
    n_cmp++; if (rd_data[0] !== 32'hA000_0001) begin n_bad++; $display("FAIL wrap_word0: got %h expected a0000001", rd_data[0]); end
  endtask

  task automatic test_rready_stall;
    int cyc;
    axi_write(4'd6, 32'h80, 8'd3, 2'b01, 32'hB000_0000, 4'hF, 3);
    axi_arid = 4'd7; axi_araddr = 32'h80; axi_arlen = 8'd3; axi_arburst = 2'b01;
    axi_arvalid = 1'b1; axi_rready = 1'b1;
    cyc = 0;
    while (!axi_arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    n_cmp++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hB000_0000) begin n_bad++; $display("FAIL stall_beat0: got v=%b %h expected 1 b0000000", axi_rvalid, axi_rdata); end
    @(posedge clk); #1;
    n_cmp++; if (axi_rdata !== 32'hB000_0001) begin n_bad++; $display("FAIL stall_beat1: got %h expected b0000001", axi_rdata); end
    @(posedge clk); #1;
    axi_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({axi_rvalid, axi_rlast, axi_rdata} !== {1'b1, 1'b0, 32'hB000_0002}) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b l=%b %h expected 1 0 b0000002", i, axi_rvalid, axi_rlast, axi_rdata); end
      @(posedge clk); #1;
    end
    axi_rready = 1'b1;
    n_cmp++; if (axi_rdata !== 32'hB000_0002) begin n_bad++; $display("FAIL stall_resume2: got %h expected b0000002", axi_rdata); end
    @(posedge clk); #1;
    n_cmp++; if ({axi_rvalid, axi_rlast, axi_rdata} !== {1'b1, 1'b1, 32'hB000_0003}) begin n_bad++; $display("FAIL stall_resume3: got v=%b l=%b %h expected 1 1 b0000003", axi_rvalid, axi_rlast, axi_rdata); end
    @(posedge clk); #1;
    axi_rready = 1'b0;
    n_cmp++; if (axi_rvalid !== 1'b0) begin n_bad++; $display("FAIL stall_end: got %b expected 0", axi_rvalid); end
  endtask

  task automatic test_write_errors;
    axi_write(4'd7, 32'h100, 8'd3, 2'b01, 32'hC000_0000, 4'hF, 1);
    n_cmp++; if (!wr_ok) begin n_bad++; $display("FAIL early_wlast_beats: got ok=%b expected 1", wr_ok); end
    n_cmp++; if (wr_resp !== 2'b10 || wr_bid !== 4'd7) begin n_bad++; $display("FAIL early_wlast_b: got %b/%h expected 10/7", wr_resp, wr_bid); end
    read_burst(4'd0, 32'h10C, 8'd0, 2'b01);
    n_cmp++; if (rd_data[0] !== 32'hC000_0003) begin n_bad++; $display("FAIL early_wlast_mem: got %h expected c0000003", rd_data[0]); end
    axi_write(4'd8, 32'h140, 8'd1, 2'b01, 32'hE000_0000, 4'hF, -1);
    n_cmp++; if (!wr_ok || wr_resp !== 2'b10) begin n_bad++; $display("FAIL missing_wlast_b: got ok=%b %b expected 1 10", wr_ok, wr_resp); end
    axi_write(4'd9, 32'h200, 8'd1, 2'b01, 32'h5555_0000, 4'hF, 1);
    n_cmp++; if (wr_resp !== 2'b00) begin n_bad++; $display("FAIL good_write_b: got %b expected 00", wr_resp); end
    axi_write(4'd9, 32'h200, 8'd1, 2'b00, 32'hD000_0000, 4'hF, 1);
    n_cmp++; if (!wr_ok || wr_resp !== 2'b10) begin n_bad++; $display("FAIL fixed_burst_b: got ok=%b %b expected 1 10", wr_ok, wr_resp); end
    read_burst(4'd0, 32'h200, 8'd1, 2'b01);
    n_cmp++; if (rd_data[0] !== 32'h5555_0000 || rd_data[1] !== 32'h5555_0001) begin n_bad++; $display("FAIL fixed_burst_mem: got %h %h expected 55550000 55550001", rd_data[0], rd_data[1]); end
    read_burst(4'd2, 32'h200, 8'd1, 2'b10);
    n_cmp++; if (!rd_ok || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10) begin n_bad++; $display("FAIL read_slverr_resp: got %b %b expected 10 10", rd_resp[0], rd_resp[1]); end
    n_cmp++; if (rd_data[1] !== 32'h5555_0001) begin n_bad++; $display("FAIL read_slverr_data: got %h expected 55550001", rd_data[1]); end
  endtask

  task automatic test_same_cycle;
    int cyc;
    axi_write(4'd2, 32'h300, 8'd0, 2'b01, 32'h0BAD_F00D, 4'hF, 0);
    axi_awid = 4'd3; axi_awaddr = 32'h300; axi_awlen = 8'd0; axi_awburst = 2'b01;
    axi_awvalid = 1'b1;
    cyc = 0;
    while (!axi_awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b1; axi_wdata = 32'hC0FF_EE00; axi_wstrb = 4'hF; axi_wlast = 1'b1;
    axi_arid = 4'd4; axi_araddr = 32'h300; axi_arlen = 8'd0; axi_arburst = 2'b01;
    axi_arvalid = 1'b1; axi_rready = 1'b0;
    n_cmp++; if ({axi_wready, axi_arready} !== 2'b11) begin n_bad++; $display("FAIL concurrent_ready: got %b expected 11", {axi_wready, axi_arready}); end
    @(posedge clk); #1;
    axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_arvalid = 1'b0;
    n_cmp++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h0BAD_F00D || axi_rid !== 4'd4) begin n_bad++; $display("FAIL same_cycle_old: got v=%b %h id=%h expected 1 0badf00d 4", axi_rvalid, axi_rdata, axi_rid); end
    n_cmp++; if ({axi_bvalid, axi_bresp, axi_bid} !== {1'b1, 2'b00, 4'd3}) begin n_bad++; $display("FAIL same_cycle_b: got %b %b %h expected 1 00 3", axi_bvalid, axi_bresp, axi_bid); end
    axi_rready = 1'b1; axi_bready = 1'b1;
    @(posedge clk); #1;
    axi_rready = 1'b0; axi_bready = 1'b0;
    n_cmp++; if ({axi_rvalid, axi_bvalid} !== 2'b00) begin n_bad++; $display("FAIL same_cycle_done: got %b expected 00", {axi_rvalid, axi_bvalid}); end
    read_burst(4'd5, 32'h300, 8'd0, 2'b01);
    n_cmp++; if (rd_data[0] !== 32'hC0FF_EE00) begin n_bad++; $display("FAIL same_cycle_new: got %h expected c0ffee00", rd_data[0]); end
  endtask

  task automatic test_reset_mid_burst;
    int cyc;
    logic seen_b;
    axi_awid = 4'd6; axi_awaddr = 32'h400; axi_awlen = 8'd3; axi_awburst = 2'b01;
    axi_awvalid = 1'b1;
    cyc = 0;
    while (!axi_awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b1; axi_wdata = 32'h7777_0000; axi_wstrb = 4'hF; axi_wlast = 1'b0;
    axi_arid = 4'd1; axi_araddr = 32'h300; axi_arlen = 8'd1; axi_arburst = 2'b01;
    axi_arvalid = 1'b1; axi_rready = 1'b0;
    @(posedge clk); #1;
    axi_arvalid = 1'b0; axi_wvalid = 1'b0;
    n_cmp++; if ({axi_rvalid, axi_awready} !== 2'b10) begin n_bad++; $display("FAIL midburst_pre: got %b expected 10", {axi_rvalid, axi_awready}); end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({axi_arready, axi_awready} !== 2'b11) begin n_bad++; $display("FAIL midburst_ready: got %b expected 11", {axi_arready, axi_awready}); end
    n_cmp++; if ({axi_bvalid, axi_rvalid, axi_wready} !== 3'b000) begin n_bad++; $display("FAIL midburst_valid: got %b expected 000", {axi_bvalid, axi_rvalid, axi_wready}); end
    resetn = 1'b1; axi_bready = 1'b1;
    seen_b = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen_b = seen_b | axi_bvalid; end
    axi_bready = 1'b0;
    n_cmp++; if (seen_b !== 1'b0) begin n_bad++; $display("FAIL midburst_no_b: got %b expected 0", seen_b); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = 3'd2; axi_arburst = 2'b01;
    axi_arlock = '0; axi_arcache = '0; axi_arprot = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = 3'd2; axi_awburst = 2'b01;
    axi_awlock = '0; axi_awcache = '0; axi_awprot = '0; axi_awvalid = 1'b0;
    axi_wid = '0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    test_reset;
    test_read_burst;
    test_write_strobe;
    test_read_wrap;
    test_rready_stall;
    test_write_errors;
    test_same_cycle;
    test_reset_mid_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
